// File: rtl/com_tx_pkg.sv
// Shared types and constants for the result-word UART transmitter.
// Provides the FSM state type, the end-of-transmission byte and the
// framing constants used by com_result_tx.
package com_tx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        START    = 3'd2,
        DATA     = 3'd3,
        STOP     = 3'd4,
        EOT_LOAD = 3'd5
    } tx_state_t;

    localparam logic [7:0]  EOT_BYTE       = 8'h04;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BITS_PER_BYTE  = 8;

endpackage

// File: rtl/com_result_tx_if.sv
// Bus between the communication stage / board pin and com_result_tx.
// Signals:
//   WordValid  one-cycle strobe qualifying WordIn
//   WordIn     result word to send
//   EndFlag    end-of-program level from the CPU
//   Tx         UART line, idle high
//   Busy       frame in progress, words queued or EOT pending
//   FifoFull   word buffer full
//   Overflow   sticky: a word was dropped
//   Done       sticky: EOT byte fully sent
// master: the side producing words (CPU side); slave: the transmitter.
interface com_result_tx_if #(
    parameter int unsigned DATA_W = 32
);
    logic              WordValid;
    logic [DATA_W-1:0] WordIn;
    logic              EndFlag;
    logic              Tx;
    logic              Busy;
    logic              FifoFull;
    logic              Overflow;
    logic              Done;

    modport master (
        output WordValid, WordIn, EndFlag,
        input  Tx, Busy, FifoFull, Overflow, Done
    );

    modport slave (
        input  WordValid, WordIn, EndFlag,
        output Tx, Busy, FifoFull, Overflow, Done
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding result words awaiting transmission.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   push        write request; ignored while full (no write-through)
//   pushData    data written on push
//   pop         read request; ignored while empty
//   popData     head entry (valid while not empty)
//   full        registered: count == DEPTH
//   empty       registered: count == 0
//   count       registered occupancy
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] countNext;
    logic             pushOk;
    logic             popOk;

    // Full/empty come from the registered count, so a pop never frees room
    // for a push in the same cycle.
    always_comb begin
        pushOk    = push && !full;
        popOk     = pop && !empty;
        countNext = count + CNT_W'(pushOk) - CNT_W'(popOk);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
            if (popOk)  rdPtr <= rdPtr + PTR_W'(1);
            count <= countNext;
            full  <= (countNext == CNT_W'(DEPTH));
            empty <= (countNext == '0);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (pushOk) mem[wrPtr] <= pushData;
    end

    assign popData = mem[rdPtr];

endmodule

// File: rtl/com_result_tx.sv
// Buffers CPU result words and serializes them MSB byte first on a UART 8N1
// line; after a rising EndFlag it sends a single EOT byte once the buffer
// has drained.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset (takes effect mid-frame)
//   bus    com_result_tx_if.slave: WordValid/WordIn/EndFlag in,
//          Tx/Busy/FifoFull/Overflow/Done out (all registered)
module com_result_tx
    import com_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned DATA_W       = 32
) (
    input  logic           clk,
    input  logic           reset,
    com_result_tx_if.slave bus
);
    localparam int unsigned TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(CLKS_PER_BIT - 1);

    tx_state_t          state, stateNext;
    logic [TIMER_W-1:0] timer, timerNext;
    logic [2:0]         bitCnt, bitCntNext;
    logic [1:0]         byteCnt, byteCntNext;
    logic [DATA_W-1:0]  shiftReg, shiftNext;
    logic [7:0]         byteReg, byteNext;
    logic               isEot, isEotNext;
    logic               endPending, endPendingNext;
    logic               endFlagPrev;
    logic               eotSent;

    logic               txQ, txNext;
    logic               busyQ, busyNext;
    logic               fifoFullQ, fifoFullNext;
    logic               overflowQ, overflowNext;
    logic               doneQ, doneNext;

    logic               fifoPush;
    logic               fifoPop;
    logic [DATA_W-1:0]  fifoPopData;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [CNT_W-1:0]   fifoCount;
    logic [CNT_W-1:0]   countNext;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifoPush),
        .pushData (bus.WordIn),
        .pop      (fifoPop),
        .popData  (fifoPopData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        stateNext   = state;
        timerNext   = timer;
        bitCntNext  = bitCnt;
        byteCntNext = byteCnt;
        shiftNext   = shiftReg;
        byteNext    = byteReg;
        isEotNext   = isEot;
        doneNext    = doneQ;
        eotSent     = 1'b0;
        fifoPop     = 1'b0;

        case (state)
            IDLE: begin
                // Queued words take priority over a pending EOT.
                if (!fifoEmpty) begin
                    fifoPop     = 1'b1;
                    shiftNext   = fifoPopData;
                    byteCntNext = 2'd0;
                    isEotNext   = 1'b0;
                    stateNext   = LOAD;
                end else if (endPending) begin
                    stateNext = EOT_LOAD;
                end
            end
            LOAD: begin
                byteNext  = shiftReg[DATA_W-1 -: 8];
                shiftNext = {shiftReg[DATA_W-9:0], 8'h00};
                timerNext = TIMER_RELOAD;
                stateNext = START;
            end
            START: begin
                if (timer == '0) begin
                    timerNext  = TIMER_RELOAD;
                    bitCntNext = 3'd0;
                    stateNext  = DATA;
                end else begin
                    timerNext = timer - TIMER_W'(1);
                end
            end
            DATA: begin
                if (timer == '0) begin
                    timerNext = TIMER_RELOAD;
                    if (bitCnt == 3'(BITS_PER_BYTE - 1)) begin
                        stateNext = STOP;
                    end else begin
                        bitCntNext = bitCnt + 3'd1;
                    end
                end else begin
                    timerNext = timer - TIMER_W'(1);
                end
            end
            STOP: begin
                if (timer == '0) begin
                    if (isEot) begin
                        doneNext  = 1'b1;
                        eotSent   = 1'b1;
                        isEotNext = 1'b0;
                        stateNext = IDLE;
                    end else if (byteCnt != 2'(BYTES_PER_WORD - 1)) begin
                        byteCntNext = byteCnt + 2'd1;
                        stateNext   = LOAD;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    timerNext = timer - TIMER_W'(1);
                end
            end
            EOT_LOAD: begin
                byteNext  = EOT_BYTE;
                isEotNext = 1'b1;
                timerNext = TIMER_RELOAD;
                stateNext = START;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Tx is registered, so it is derived from the state being entered.
        case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = byteNext[bitCntNext];
            default: txNext = 1'b1;
        endcase

        // A fresh rising edge wins over the clear from a just-finished EOT.
        endPendingNext = (endPending && !eotSent) || (bus.EndFlag && !endFlagPrev);

        fifoPush     = bus.WordValid && !fifoFull;
        overflowNext = overflowQ || (bus.WordValid && fifoFull);
        countNext    = fifoCount + CNT_W'(fifoPush) - CNT_W'(fifoPop);
        fifoFullNext = (countNext == CNT_W'(FIFO_DEPTH));
        busyNext     = (stateNext != IDLE) || (countNext != '0) || endPendingNext;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            bitCnt      <= 3'd0;
            byteCnt     <= 2'd0;
            shiftReg    <= '0;
            byteReg     <= 8'h00;
            isEot       <= 1'b0;
            endPending  <= 1'b0;
            endFlagPrev <= 1'b0;
            txQ         <= 1'b1;
            busyQ       <= 1'b0;
            fifoFullQ   <= 1'b0;
            overflowQ   <= 1'b0;
            doneQ       <= 1'b0;
        end else begin
            state       <= stateNext;
            timer       <= timerNext;
            bitCnt      <= bitCntNext;
            byteCnt     <= byteCntNext;
            shiftReg    <= shiftNext;
            byteReg     <= byteNext;
            isEot       <= isEotNext;
            endPending  <= endPendingNext;
            endFlagPrev <= bus.EndFlag;
            txQ         <= txNext;
            busyQ       <= busyNext;
            fifoFullQ   <= fifoFullNext;
            overflowQ   <= overflowNext;
            doneQ       <= doneNext;
        end
    end

    assign bus.Tx       = txQ;
    assign bus.Busy     = busyQ;
    assign bus.FifoFull = fifoFullQ;
    assign bus.Overflow = overflowQ;
    assign bus.Done     = doneQ;

endmodule

// File: tb/tb_com_result_tx.sv
// Self-checking bench for com_result_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// A UART receiver on Tx rebuilds the byte stream, which is compared with
// byte streams derived from the words sent.
module tb_com_result_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;

    com_result_tx_if #(.DATA_W(32)) bus ();

    com_result_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_W       (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] rxQ[$];
    logic [7:0] expQ[$];

    bit         rxActive = 1'b0;
    int         rxC      = 0;
    logic [7:0] rxSh     = 8'h00;

    typedef struct {
        string        name;
        logic [31:0]  w0;
        logic [31:0]  w1;
        int           nWords;
        int           endMode;   // 0 none, 1 with last word, 2 cycle after
        int           nBytes;
        logic [71:0]  stream;    // expected bytes, first byte most significant
        bit           expDone;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (bus.Busy === 1'b1 && n < 5000) begin
            step(1);
            n++;
        end
        check(name, 32'(bus.Busy), 32'd0);
        step(3);
    endtask

    task automatic compareStream(input string name);
        int n;
        check({name, "_len"}, 32'(rxQ.size()), 32'(expQ.size()));
        n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_byte"}, 32'(rxQ[i]), 32'(expQ[i]));
        end
        rxQ.delete();
        expQ.delete();
    endtask

    task automatic expectWord(input logic [31:0] w);
        for (int b = 0; b < 4; b++) expQ.push_back(8'(w >> (8 * (3 - b))));
    endtask

    // UART 8N1 receiver sampling mid-bit on the falling clock edge.
    initial begin : uart_rx
        forever begin
            @(negedge clk);
            if (reset) begin
                rxActive = 1'b0;
            end else if (!rxActive) begin
                if (bus.Tx == 1'b0) begin
                    rxActive = 1'b1;
                    rxC      = 0;
                end
            end else begin
                rxC++;
                if (rxC % CPB == CPB / 2) begin
                    if (rxC / CPB == 0) begin
                        check("start_bit", 32'(bus.Tx), 32'd0);
                    end else if (rxC / CPB <= 8) begin
                        rxSh[3'(rxC / CPB - 1)] = bus.Tx;
                    end else begin
                        check("stop_bit", 32'(bus.Tx), 32'd1);
                        rxQ.push_back(rxSh);
                        rxActive = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [71:0] s;
        logic [31:0] w;
        bit          doneModel;
        int          nw;
        int          mode;

        vecs[0] = '{"pattern",  32'h00FF8001, 32'h0,        1, 0, 4, 72'h00FF8001,           1'b0};
        vecs[1] = '{"priority", 32'h11223344, 32'h0,        1, 1, 5, 72'h1122334404,         1'b1};
        vecs[2] = '{"end_mark", 32'hCAFEF00D, 32'h01020304, 2, 2, 9, 72'hCAFEF00D0102030404, 1'b1};
        vecs[3] = '{"post_done",32'hDEADBEEF, 32'h0,        1, 0, 4, 72'hDEADBEEF,           1'b1};

        reset         = 1'b1;
        bus.WordValid = 1'b0;
        bus.WordIn    = 32'h0;
        bus.EndFlag   = 1'b0;
        step(2);
        check("rst_tx",       32'(bus.Tx),       32'd1);
        check("rst_busy",     32'(bus.Busy),     32'd0);
        check("rst_fifofull", 32'(bus.FifoFull), 32'd0);
        check("rst_overflow", 32'(bus.Overflow), 32'd0);
        check("rst_done",     32'(bus.Done),     32'd0);
        reset = 1'b0;
        step(2);
        check("post_rst_tx",   32'(bus.Tx),   32'd1);
        check("post_rst_busy", 32'(bus.Busy), 32'd0);

        // Single word: latency, bit timing and Busy fall.
        bus.WordValid = 1'b1;
        bus.WordIn    = 32'hA1B2C3D4;
        step(1);                                   // edge k
        bus.WordValid = 1'b0;
        check("lat_busy_k", 32'(bus.Busy), 32'd1);
        step(1);
        check("lat_tx_k1", 32'(bus.Tx), 32'd1);
        step(1);
        check("lat_tx_k2", 32'(bus.Tx), 32'd0);
        step(3);
        check("lat_tx_k5", 32'(bus.Tx), 32'd0);
        step(1);
        check("lat_bit0_k6", 32'(bus.Tx), 32'd1);
        step(3);
        check("lat_bit0_k9", 32'(bus.Tx), 32'd1);
        step(1);
        check("lat_bit1_k10", 32'(bus.Tx), 32'd0);
        step(154);
        check("lat_busy_k164", 32'(bus.Busy), 32'd1);
        check("lat_stop_k164", 32'(bus.Tx),   32'd1);
        step(1);
        check("lat_busy_k165", 32'(bus.Busy), 32'd0);
        step(2);
        expectWord(32'hA1B2C3D4);
        compareStream("single");

        // Table-driven scenarios.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < vecs[r].nWords; i++) begin
                bus.WordValid = 1'b1;
                bus.WordIn    = (i == 0) ? vecs[r].w0 : vecs[r].w1;
                if (vecs[r].endMode == 1 && i == vecs[r].nWords - 1) bus.EndFlag = 1'b1;
                step(1);
            end
            bus.WordValid = 1'b0;
            if (vecs[r].endMode == 2) bus.EndFlag = 1'b1;
            if (vecs[r].endMode != 0) begin
                step(50);
                bus.EndFlag = 1'b0;
            end
            waitIdle({vecs[r].name, "_idle"});
            s = vecs[r].stream;
            for (int i = 0; i < vecs[r].nBytes; i++) expQ.push_back(8'(s >> (8 * (vecs[r].nBytes - 1 - i))));
            compareStream(vecs[r].name);
            check({vecs[r].name, "_done"}, 32'(bus.Done), 32'(vecs[r].expDone));
        end

        // Overflow: ten back-to-back words, the tenth is dropped.
        for (int e = 1; e <= 10; e++) begin
            bus.WordValid = 1'b1;
            bus.WordIn    = 32'(e);
            step(1);
            check("ovf_fifofull", 32'(bus.FifoFull), (e >= 9)  ? 32'd1 : 32'd0);
            check("ovf_overflow", 32'(bus.Overflow), (e >= 10) ? 32'd1 : 32'd0);
        end
        bus.WordValid = 1'b0;
        waitIdle("ovf_idle");
        for (int e = 1; e <= 9; e++) expectWord(32'(e));
        compareStream("ovf");
        check("ovf_sticky", 32'(bus.Overflow), 32'd1);

        // Reset during DATA of the second byte, with a second word queued.
        bus.WordValid = 1'b1;
        bus.WordIn    = 32'hA1B2C3D4;
        step(1);                                   // edge k
        bus.WordIn    = 32'h12345678;
        step(1);                                   // edge k+1
        bus.WordValid = 1'b0;
        step(47);                                  // edge k+48
        check("mid_tx_b2bit0", 32'(bus.Tx),   32'd0);
        check("mid_busy",      32'(bus.Busy), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_tx",       32'(bus.Tx),       32'd1);
        check("arst_busy",     32'(bus.Busy),     32'd0);
        check("arst_overflow", 32'(bus.Overflow), 32'd0);
        check("arst_done",     32'(bus.Done),     32'd0);
        step(2);
        reset = 1'b0;
        rxQ.delete();
        step(2);
        bus.WordValid = 1'b1;
        bus.WordIn    = 32'h00000055;
        step(1);
        bus.WordValid = 1'b0;
        waitIdle("arst_idle");
        expQ.push_back(8'h00);
        expQ.push_back(8'h00);
        expQ.push_back(8'h00);
        expQ.push_back(8'h55);
        compareStream("after_rst");
        check("after_rst_done", 32'(bus.Done), 32'd0);

        // Random bursts against the byte-stream model.
        doneModel = 1'b0;
        for (int it = 0; it < 6; it++) begin
            nw   = $urandom_range(1, 9);
            mode = $urandom_range(0, 2);
            for (int i = 0; i < nw; i++) begin
                w = $urandom;
                expectWord(w);
                bus.WordValid = 1'b1;
                bus.WordIn    = w;
                if (mode == 1 && i == nw - 1) bus.EndFlag = 1'b1;
                step(1);
                bus.WordValid = 1'b0;
                step($urandom_range(0, 3));
            end
            if (mode == 2) bus.EndFlag = 1'b1;
            if (mode != 0) begin
                expQ.push_back(8'h04);
                doneModel = 1'b1;
                step($urandom_range(1, 20));
                bus.EndFlag = 1'b0;
            end
            waitIdle("rnd_idle");
            compareStream("rnd");
            check("rnd_done",     32'(bus.Done),     32'(doneModel));
            check("rnd_overflow", 32'(bus.Overflow), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/com_result_tx.md
Name: com_result_tx

Overview:
Downstream consumer of the CPU's communication result word (ReadDataOut, qualified by a strobe). It buffers 32-bit result words in a small FIFO and serializes them to a host over a UART 8N1 line, most-significant byte first. After the program's end flag it sends a single end-of-transmission byte. It sits beside the processor top and drives the board's TX pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2
FIFO_DEPTH, 8, word entries in the buffer; power of two, ≥ 2
DATA_W, 32, result word width; fixed at 32 (4 bytes)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
WordValid  in  1  one-cycle strobe: WordIn holds a result to send
WordIn  in  32  result word from the communication stage
EndFlag  in  1  CPU end-of-program flag; level, may stay high
Tx  out  1  UART serial line, idle high
Busy  out  1  high while a frame is in progress or the FIFO is non-empty
FifoFull  out  1  FIFO count == FIFO_DEPTH
Overflow  out  1  sticky: a word was dropped
Done  out  1  sticky: EOT byte fully sent

Behaviour:
- Reset (async): Tx=1, Busy=0, FifoFull=0, Overflow=0, Done=0, FIFO emptied, EndPending=0, FSM=IDLE. Takes effect immediately, including mid-frame.
- FIFO write: on a clock edge with WordValid=1 and registered count < FIFO_DEPTH. If count == FIFO_DEPTH, the word is dropped and Overflow is set. This holds even if a pop occurs in the same cycle; no write-through when full.
- EndFlag: a rising edge (registered previous value) sets EndPending. A level held high produces only one EOT.
- FSM states: IDLE, LOAD, START, DATA, STOP, EOT_LOAD.
  - IDLE: if FIFO non-empty, pop into a 32-bit shift register, set byte_cnt=0, go to LOAD. Otherwise, if EndPending, go to EOT_LOAD. Otherwise stay. FIFO words have priority over EOT.
  - LOAD: load the byte register with the word's byte[3-byte_cnt] (MSB first), reset the bit timer, go to START. Tx=1 during this cycle.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt=0.
  - DATA: Tx=byte[bit_cnt], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles. Then:
    - EOT byte just sent: set Done, clear EndPending, go to IDLE.
    - byte_cnt < 3: increment byte_cnt, go to LOAD.
    - otherwise: go to IDLE.
  - EOT_LOAD: load 8'h04, mark the frame as EOT, go to START.
- Timing:
  - Bit timer counts CLKS_PER_BIT-1 down to 0.
  - A byte occupies 1 LOAD cycle + 10*CLKS_PER_BIT cycles.
  - Word latency: WordValid at edge k into an idle, empty FIFO gives pop at k+1, LOAD at k+1..k+2, Tx=0 from edge k+2.
  - Between words: one IDLE cycle plus one LOAD cycle of Tx=1.
- Words arriving after Done are still accepted and sent. Done stays 1. A new EndFlag rising edge sends another EOT.
- Busy = (state != IDLE) || (count != 0) || EndPending.
- FIFO pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits wide.

Decomposition:
- Package com_tx_pkg: state enum tx_state_t, EOT_BYTE = 8'h04, BYTES_PER_WORD = 4.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count; async active-high reset). It holds the word buffer; the FSM, bit timer and shifter stay in com_result_tx.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=8.
1. Single word: WordIn=32'hA1B2C3D4 with WordValid for 1 cycle.
   - Tx decodes to bytes A1, B2, C3, D4, each with start=0 and stop=1.
   - First start bit begins 2 edges after the strobe; each bit lasts 4 cycles.
   - Busy falls after the last stop bit.
2. Overflow: 10 consecutive WordValid cycles with words 1..10 while idle.
   - Words 1..9 are transmitted in order; word 10 is dropped.
   - FifoFull=1 at edge 9; Overflow=1 from edge 10 and stays 1.
3. End marker: 2 words queued, then EndFlag rises and stays high for 50 cycles.
   - Tx sends 8 data bytes, then exactly one 0x04.
   - Done=1 after the EOT stop bit; Busy=0.
4. Reset mid-frame: assert reset during DATA of byte B2.
   - Tx=1 and Busy=0 immediately (before the next clock edge); FIFO empty; Overflow/Done cleared.
   - After release, WordIn=32'h00000055 is transmitted as 00, 00, 00, 55.
5. Priority: EndFlag rises in the same cycle as WordValid=32'h11223344 on an empty FIFO.
   - Bytes 11, 22, 33, 44 are sent before 0x04.
6. Post-Done: after scenario 3, send WordIn=32'hDEADBEEF.
   - DE, AD, BE, EF are transmitted; Done remains 1; no second EOT.
